alu_op_sequencer: RTL and testbench

Multicycle initiator for the ALU control interface. It accepts a decoded instruction (opcode/funct) and issues the 5-bit control_type code consumed by the ALU control decoder. It sequences single-cycle ALU ops, branch conditions, and multi-cycle mult/div ops, which need a start/done handshake. It samples the datapath status flags and returns one response per instruction to the main control FSM.

---
 rtl/alu_ctrl_defs.sv | 54 +++++
 rtl/alu_op_decode.sv | 53 +++++
 rtl/alu_op_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_defs.sv
// Shared definitions for the ALU control path: control_type codes, opcode/funct
// constants, sequencer state encoding and the decoder result bundle.
package alu_ctrl_defs;

    localparam logic [4:0] CT_NOP   = 5'b00000;
    localparam logic [4:0] CT_ADD   = 5'b00001;
    localparam logic [4:0] CT_SUB   = 5'b00010;
    localparam logic [4:0] CT_AND   = 5'b00011;
    localparam logic [4:0] CT_SUBOV = 5'b00100;
    localparam logic [4:0] CT_XOR   = 5'b00101;
    localparam logic [4:0] CT_NOR   = 5'b00110;
    localparam logic [4:0] CT_SLT   = 5'b00111;
    localparam logic [4:0] CT_OR    = 5'b01000;
    localparam logic [4:0] CT_DIV   = 5'b01001;
    localparam logic [4:0] CT_MULT  = 5'b01010;
    localparam logic [4:0] CT_ADDU  = 5'b01011;
    localparam logic [4:0] CT_MFHI  = 5'b01100;
    localparam logic [4:0] CT_MFLO  = 5'b01101;
    localparam logic [4:0] CT_BEQ   = 5'b01110;
    localparam logic [4:0] CT_BNE   = 5'b01111;
    localparam logic [4:0] CT_BLE   = 5'b10000;
    localparam logic [4:0] CT_BGT   = 5'b10001;
    localparam logic [4:0] CT_LUI   = 5'b10010;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLE   = 6'h06;
    localparam logic [5:0] OP_BGT   = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_MD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decoder producing the ALU control_type code and
// the per-instruction attributes the sequencer and main control FSM need.
module alu_op_decode
    import alu_ctrl_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [4:0] code,
    output logic       illegal,
    output logic       is_md,
    output logic       is_branch,
    output logic       chk_ovf
);

    always_comb begin
        code    = CT_NOP;
        illegal = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  code = CT_ADD;
                FN_SUB:  code = CT_SUB;
                FN_AND:  code = CT_AND;
                FN_OR:   code = CT_OR;
                FN_SLT:  code = CT_SLT;
                FN_MULT: code = CT_MULT;
                FN_DIV:  code = CT_DIV;
                FN_MFHI: code = CT_MFHI;
                FN_MFLO: code = CT_MFLO;
                default: illegal = 1'b1;
            endcase
        end else begin
            case (opcode)
                OP_ADDI:  code = CT_ADD;
                OP_ADDIU: code = CT_ADDU;
                OP_SLTI:  code = CT_SLT;
                OP_LW:    code = CT_ADDU;
                OP_SW:    code = CT_ADDU;
                OP_BEQ:   code = CT_BEQ;
                OP_BNE:   code = CT_BNE;
                OP_BLE:   code = CT_BLE;
                OP_BGT:   code = CT_BGT;
                OP_LUI:   code = CT_LUI;
                default:  illegal = 1'b1;
            endcase
        end
    end

    assign is_md     = (code == CT_MULT) || (code == CT_DIV);
    assign is_branch = (code >= CT_BEQ) && (code <= CT_BGT);
    // Only signed add/sub style codes can raise an overflow exception.
    assign chk_ovf   = (code == CT_ADD) || (code == CT_SUB) || (code == CT_SUBOV);

endmodule

// File: rtl/alu_op_sequencer.sv
// Multicycle ALU control initiator: decode, execute, optional mult/div wait, respond.
// Optional mult/div watchdog enabled by defining ALU_SEQ_MD_TIMEOUT_EN.
module alu_op_sequencer
    import alu_ctrl_defs::*;
#(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [4:0] control_type,
    output logic       ctrl_valid,
    output logic       md_start,
    input  logic       md_done,
    input  logic       div_zero,
    input  logic       ovf_in,
    input  logic       cond_true,
    output logic       resp_valid,
    output logic       exc_overflow,
    output logic       exc_divzero,
    output logic       branch_taken,
    output logic       illegal,
    output logic       md_timeout,
    output seq_state_e dbg_state
);

    logic [4:0] dec_code;
    logic       dec_illegal, dec_is_md, dec_is_branch, dec_chk_ovf;

    alu_op_decode u_decode (
        .opcode    (opcode),
        .funct     (funct),
        .code      (dec_code),
        .illegal   (dec_illegal),
        .is_md     (dec_is_md),
        .is_branch (dec_is_branch),
        .chk_ovf   (dec_chk_ovf)
    );

    seq_state_e state_q;
    logic [4:0] ct_q;
    logic       ready_q, cv_q, md_start_q, resp_q;
    logic       ovf_q, dz_q, br_q, ill_q;
    logic       is_md_q, is_div_q, is_branch_q, chk_ovf_q;

`ifdef ALU_SEQ_MD_TIMEOUT_EN
    localparam int CNT_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MD_LIMIT = CNT_W'(MD_TIMEOUT - 1);
    logic [CNT_W-1:0] md_cnt_q;
    logic             to_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            ct_q        <= CT_NOP;
            cv_q        <= 1'b0;
            md_start_q  <= 1'b0;
            resp_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            br_q        <= 1'b0;
            ill_q       <= 1'b0;
            is_md_q     <= 1'b0;
            is_div_q    <= 1'b0;
            is_branch_q <= 1'b0;
            chk_ovf_q   <= 1'b0;
`ifdef ALU_SEQ_MD_TIMEOUT_EN
            md_cnt_q    <= '0;
            to_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        ready_q     <= 1'b0;
                        is_md_q     <= dec_is_md;
                        is_div_q    <= (dec_code == CT_DIV);
                        is_branch_q <= dec_is_branch;
                        chk_ovf_q   <= dec_chk_ovf;
                        if (dec_illegal) begin
                            state_q <= ST_RESP;
                            resp_q  <= 1'b1;
                            ill_q   <= 1'b1;
                        end else begin
                            state_q    <= ST_EXEC;
                            cv_q       <= 1'b1;
                            ct_q       <= dec_code;
                            md_start_q <= dec_is_md;
                        end
                    end
                end
                ST_EXEC: begin
                    md_start_q <= 1'b0;
                    if (is_md_q) begin
                        state_q <= ST_MD_WAIT;
`ifdef ALU_SEQ_MD_TIMEOUT_EN
                        md_cnt_q <= '0;
`endif
                    end else begin
                        state_q <= ST_RESP;
                        cv_q    <= 1'b0;
                        ct_q    <= CT_NOP;
                        resp_q  <= 1'b1;
                        ovf_q   <= chk_ovf_q & ovf_in;
                        br_q    <= is_branch_q & cond_true;
                    end
                end
                ST_MD_WAIT: begin
                    // control_type stays on the mult/div code until completion.
                    if (md_done) begin
                        state_q <= ST_RESP;
                        cv_q    <= 1'b0;
                        ct_q    <= CT_NOP;
                        resp_q  <= 1'b1;
                        dz_q    <= is_div_q & div_zero;
                    end
`ifdef ALU_SEQ_MD_TIMEOUT_EN
                    else if (md_cnt_q == MD_LIMIT) begin
                        state_q <= ST_RESP;
                        cv_q    <= 1'b0;
                        ct_q    <= CT_NOP;
                        resp_q  <= 1'b1;
                        to_q    <= 1'b1;
                    end else begin
                        md_cnt_q <= md_cnt_q + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                    dz_q    <= 1'b0;
                    br_q    <= 1'b0;
                    ill_q   <= 1'b0;
`ifdef ALU_SEQ_MD_TIMEOUT_EN
                    to_q    <= 1'b0;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready  = ready_q;
    assign control_type = ct_q;
    assign ctrl_valid   = cv_q;
    assign md_start     = md_start_q;
    assign resp_valid   = resp_q;
    assign exc_overflow = ovf_q;
    assign exc_divzero  = dz_q;
    assign branch_taken = br_q;
    assign illegal      = ill_q;
    assign dbg_state    = state_q;
`ifdef ALU_SEQ_MD_TIMEOUT_EN
    assign md_timeout   = to_q;
`else
    assign md_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: transaction-level model builds the expected
// per-cycle output trace; define ALU_SEQ_MD_TIMEOUT_EN to cover the watchdog.
module tb_alu_op_sequencer;
  import alu_ctrl_defs::*;

  localparam int W = 14;
`ifdef ALU_SEQ_MD_TIMEOUT_EN
  localparam int MD_TO = 8;
`else
  localparam int MD_TO = 64;
`endif
  // Bit positions of the packed output vector.
  localparam int B_RDY = 13, B_CV = 12, B_MS = 6, B_RV = 5, B_EO = 4, B_ED = 3, B_BR = 2, B_IL = 1, B_TO = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic instr_valid = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic md_done = 1'b0, div_zero = 1'b0, ovf_in = 1'b0, cond_true = 1'b0;
  logic instr_ready, ctrl_valid, md_start, resp_valid;
  logic exc_overflow, exc_divzero, branch_taken, illegal, md_timeout;
  logic [4:0] control_type;
  seq_state_e dbg_state;

  always #5 clk = ~clk;

  alu_op_sequencer #(.MD_TIMEOUT(MD_TO)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct(funct), .control_type(control_type), .ctrl_valid(ctrl_valid),
    .md_start(md_start), .md_done(md_done), .div_zero(div_zero), .ovf_in(ovf_in),
    .cond_true(cond_true), .resp_valid(resp_valid), .exc_overflow(exc_overflow),
    .exc_divzero(exc_divzero), .branch_taken(branch_taken), .illegal(illegal),
    .md_timeout(md_timeout), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  string lit_name_q[$];
  int lit_got_q[$];
  int lit_exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ms_cnt = 0, cv_cnt = 0, rv_cnt = 0;
  logic [4:0] last_ct = '0;
  logic [W-1:0] last_resp = '0;

  function automatic logic [W-1:0] vec(input logic rdy, cv, input logic [4:0] ct,
                                       input logic ms, rv, eo, ed, br, il, to);
    return {rdy, cv, ct, ms, rv, eo, ed, br, il, to};
  endfunction

  localparam logic [W-1:0] IDLE_V = {1'b1, 13'b0};

  // Reference decode straight from the instruction table: returns {illegal, code}.
  function automatic logic [5:0] ref_lookup(input logic [5:0] op, fn);
    logic [5:0] r;
    r = {1'b1, 5'b00000};
    if (op == 6'h00) begin
      case (fn)
        6'h20: r = 6'b0_00001;
        6'h22: r = 6'b0_00010;
        6'h24: r = 6'b0_00011;
        6'h25: r = 6'b0_01000;
        6'h2A: r = 6'b0_00111;
        6'h18: r = 6'b0_01010;
        6'h1A: r = 6'b0_01001;
        6'h10: r = 6'b0_01100;
        6'h12: r = 6'b0_01101;
        default: r = {1'b1, 5'b00000};
      endcase
    end else begin
      case (op)
        6'h08: r = 6'b0_00001;
        6'h09: r = 6'b0_01011;
        6'h0A: r = 6'b0_00111;
        6'h23: r = 6'b0_01011;
        6'h2B: r = 6'b0_01011;
        6'h04: r = 6'b0_01110;
        6'h05: r = 6'b0_01111;
        6'h06: r = 6'b0_10000;
        6'h07: r = 6'b0_10001;
        6'h0F: r = 6'b0_10010;
        default: r = {1'b1, 5'b00000};
      endcase
    end
    return r;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    cyc++;
    got = {instr_ready, ctrl_valid, control_type, md_start, resp_valid,
           exc_overflow, exc_divzero, branch_taken, illegal, md_timeout};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs cycle=%0d got=%b exp=%b", cyc, got, e);
      end
    end
    if (md_start === 1'b1) ms_cnt++;
    if (ctrl_valid === 1'b1) begin cv_cnt++; last_ct = control_type; end
    if (resp_valid === 1'b1) begin rv_cnt++; last_resp = got; end
    while (lit_name_q.size() > 0) begin
      string n;
      int g, x;
      n = lit_name_q.pop_front();
      g = lit_got_q.pop_front();
      x = lit_exp_q.pop_front();
      checks++;
      if (g != x) begin
        errors++;
        $display("FAIL %s got=%0d exp=%0d", n, g, x);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic lit(input string n, input int g, input int x);
    lit_name_q.push_back(n);
    lit_got_q.push_back(g);
    lit_exp_q.push_back(x);
  endtask

  // One clock: expected outputs for the cycle just started, and inputs for it.
  task automatic step(input logic r, v, input logic [5:0] op, fn,
                      input logic ovf, cnd, dn, dz, input logic [W-1:0] e);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    reset = r; instr_valid = v; opcode = op; funct = fn;
    ovf_in = ovf; cond_true = cnd; md_done = dn; div_zero = dz;
  endtask

  // Run one instruction from IDLE. md_delay: MD_WAIT cycle (1-based) carrying
  // md_done; 0 means md_done never arrives. Busy cycles offer a junk ADDI.
  task automatic run_instr(input logic [5:0] op, fn, input logic ovf, cnd,
                           input int md_delay, input logic dz);
    logic [5:0] r;
    logic [4:0] code;
    logic ill, md, isdiv, br, chk, hit, timed;
    r = ref_lookup(op, fn);
    ill = r[5];
    code = r[4:0];
    md = (code == 5'b01010) || (code == 5'b01001);
    isdiv = (code == 5'b01001);
    br = (code >= 5'b01110) && (code <= 5'b10001);
    chk = (code == 5'b00001) || (code == 5'b00010) || (code == 5'b00100);
    step(0, 1, op, fn, 0, 0, 0, 0, IDLE_V);
    if (ill) begin
      step(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, vec(0, 0, 5'b0, 0, 1, 0, 0, 0, 1, 0));
    end else begin
      step(0, 1, 6'h08, 6'h00, ovf, cnd, md, dz, vec(0, 1, code, md, 0, 0, 0, 0, 0, 0));
      if (!md) begin
        step(0, 0, 6'h00, 6'h00, 0, 0, 0, 0,
             vec(0, 0, 5'b0, 0, 1, chk & ovf, 0, br & cnd, 0, 0));
      end else begin
        hit = 1'b0;
        timed = 1'b0;
        for (int k = 1; k <= 200; k++) begin
          hit = (md_delay == k);
          step(0, 1, 6'h08, 6'h00, ovf, cnd, hit, dz, vec(0, 1, code, 0, 0, 0, 0, 0, 0, 0));
          if (hit) break;
`ifdef ALU_SEQ_MD_TIMEOUT_EN
          if (k == MD_TO) begin timed = 1'b1; break; end
`endif
        end
        step(0, 0, 6'h00, 6'h00, 0, 0, 0, 0,
             vec(0, 0, 5'b0, 0, 1, 0, hit & isdiv & dz, 0, 0, timed));
      end
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int a_ms, a_cv, a_rv;
    step(1, 0, 6'h00, 6'h00, 0, 0, 0, 0, IDLE_V);
    step(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, IDLE_V);

    // ADD with overflow raised during EXEC
    run_instr(6'h00, 6'h20, 1, 0, 0, 0);
    lit("add_ct", last_ct, 5'b00001);
    lit("add_exc_overflow", last_resp[B_EO], 1);
    // ADDIU ignores overflow
    run_instr(6'h09, 6'h00, 1, 0, 0, 0);
    lit("addiu_ct", last_ct, 5'b01011);
    lit("addiu_exc_overflow", last_resp[B_EO], 0);
    // BNE taken
    run_instr(6'h05, 6'h00, 0, 1, 0, 0);
    lit("bne_ct", last_ct, 5'b01111);
    lit("bne_taken", last_resp[B_BR], 1);
    run_instr(6'h04, 6'h00, 0, 0, 0, 0);
    run_instr(6'h06, 6'h00, 1, 1, 0, 0);
    run_instr(6'h07, 6'h00, 0, 1, 0, 0);
    run_instr(6'h00, 6'h22, 1, 1, 0, 0);
    run_instr(6'h00, 6'h2A, 1, 1, 0, 0);
    run_instr(6'h00, 6'h24, 0, 0, 0, 0);
    run_instr(6'h00, 6'h25, 1, 0, 0, 0);
    run_instr(6'h00, 6'h10, 0, 0, 0, 0);
    run_instr(6'h00, 6'h12, 0, 0, 0, 0);
    run_instr(6'h08, 6'h3F, 1, 0, 0, 0);
    run_instr(6'h0A, 6'h00, 1, 0, 0, 0);
    run_instr(6'h23, 6'h00, 0, 0, 0, 0);
    run_instr(6'h2B, 6'h00, 1, 0, 0, 0);
    run_instr(6'h0F, 6'h00, 0, 1, 0, 0);

    // MULT: md_done 5 cycles after md_start, div_zero must be ignored
    a_ms = ms_cnt; a_cv = cv_cnt;
    run_instr(6'h00, 6'h18, 0, 0, 5, 1);
    lit("mult_md_start_pulses", ms_cnt - a_ms, 1);
    lit("mult_ctrl_valid_cycles", cv_cnt - a_cv, 6);
    lit("mult_exc_divzero", last_resp[B_ED], 0);
    // DIV by zero
    run_instr(6'h00, 6'h1A, 0, 0, 2, 1);
    lit("div_exc_divzero", last_resp[B_ED], 1);
    run_instr(6'h00, 6'h1A, 0, 0, 1, 0);

    // Illegal opcode and illegal R-type funct
    a_cv = cv_cnt;
    run_instr(6'h3F, 6'h20, 0, 0, 0, 0);
    lit("illegal_ctrl_valid_cycles", cv_cnt - a_cv, 0);
    lit("illegal_flag", last_resp[B_IL], 1);
    run_instr(6'h00, 6'h3F, 0, 0, 0, 0);

    // Reset during MD_WAIT: no response, no new md_start
    a_rv = rv_cnt;
    step(0, 1, 6'h00, 6'h18, 0, 0, 0, 0, IDLE_V);
    step(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, vec(0, 1, 5'b01010, 1, 0, 0, 0, 0, 0, 0));
    step(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, vec(0, 1, 5'b01010, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, 6'h00, 6'h00, 0, 0, 0, 0, vec(0, 1, 5'b01010, 0, 0, 0, 0, 0, 0, 0));
    step(0, 0, 6'h00, 6'h00, 0, 0, 1, 1, IDLE_V);
    step(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, IDLE_V);
    step(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, IDLE_V);
    @(negedge clk);
    #1;
    lit("reset_abandon_no_resp", rv_cnt - a_rv, 0);
    run_instr(6'h00, 6'h20, 1, 0, 0, 0);

`ifdef ALU_SEQ_MD_TIMEOUT_EN
    // Watchdog: no md_done, then md_done exactly on the limit cycle
    run_instr(6'h00, 6'h1A, 0, 0, 0, 1);
    lit("timeout_flag", last_resp[B_TO], 1);
    lit("timeout_divzero", last_resp[B_ED], 0);
    run_instr(6'h00, 6'h1A, 0, 0, MD_TO, 1);
    lit("done_at_limit_timeout", last_resp[B_TO], 0);
    lit("done_at_limit_divzero", last_resp[B_ED], 1);
`endif

    step(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, IDLE_V);
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
